// File: rtl/mand_sequencer_pkg.sv
// Shared constants and state encoding for the Mandelbrot bus sequencer.
// Bank codes select the slave's position and result arrays.
package mand_sequencer_pkg;

  localparam int POINTS      = 16384;
  localparam int WAIT_CYCLES = 16392;
  localparam int IDX_W       = 14;

  localparam logic [15:0] TRIG_ADDR = 16'hfffc;

  localparam logic [1:0] BANK_POSX = 2'b00;
  localparam logic [1:0] BANK_POSY = 2'b01;
  localparam logic [1:0] BANK_XN   = 2'b10;
  localparam logic [1:0] BANK_YN   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_TRIG,
    S_WAIT,
    S_RD_X,
    S_RD_Y,
    S_EMIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/mand_sequencer_if.sv
// Position/result streams plus the slave bus of the compute unit.
// master = sequencer side, slave = fabric/compute-unit side.
interface mand_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_xn;
  logic [31:0] out_yn;
  logic        read;
  logic        write;
  logic [3:0]  be;
  logic [15:0] address;
  logic [31:0] data_out;
  logic [31:0] data_in;

  modport master (
    input  in_valid, in_x, in_y,
    input  out_ready, data_in,
    output in_ready, out_valid,
    output out_xn, out_yn,
    output read, write, be,
    output address, data_out
  );

  modport slave (
    output in_valid, in_x, in_y,
    output out_ready, data_in,
    input  in_ready, out_valid,
    input  out_xn, out_yn,
    input  read, write, be,
    input  address, data_out
  );
endinterface

// File: rtl/mand_sequencer.sv
// Loads the position banks, triggers iteration passes, then streams
// every (xn, yn) result back out. All outputs are registered.
module mand_sequencer
  import mand_sequencer_pkg::*;
#(
  parameter int N_POINTS = POINTS,
  parameter int N_WAIT   = WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] iterations,
  output logic        busy,
  output logic        done,
  mand_sequencer_if.master bus
);

  localparam int WAIT_W = $clog2(N_WAIT);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_POINTS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    WAIT_W'(N_WAIT - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [15:0]        pass_q;
  logic [15:0]        pass_d;
  logic [15:0]        iter_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [31:0]        y_q;
  logic               busy_q;
  logic               done_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               read_q;
  logic               write_q;
  logic [3:0]         be_q;
  logic [15:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        xn_q;
  logic [31:0]        yn_q;

  always_comb begin
    pass_d = pass_q + 16'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pass_q      <= '0;
      iter_q      <= '0;
      wait_q      <= '0;
      y_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      xn_q        <= '0;
      yn_q        <= '0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      be_q    <= '0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            iter_q     <= iterations;
            idx_q      <= '0;
            pass_q     <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD_X;
          end
        end
        S_LOAD_X: begin
          if (bus.in_valid) begin
            write_q    <= 1'b1;
            be_q       <= 4'hf;
            addr_q     <= {BANK_POSX, idx_q};
            wdata_q    <= bus.in_x;
            y_q        <= bus.in_y;
            in_ready_q <= 1'b0;
            state_q    <= S_LOAD_Y;
          end
        end
        S_LOAD_Y: begin
          write_q <= 1'b1;
          be_q    <= 4'hf;
          addr_q  <= {BANK_POSY, idx_q};
          wdata_q <= y_q;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            state_q <= (iter_q == 16'd0) ? S_RD_X : S_TRIG;
          end else begin
            idx_q      <= idx_q + 14'd1;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD_X;
          end
        end
        S_TRIG: begin
          write_q <= 1'b1;
          be_q    <= 4'hf;
          addr_q  <= TRIG_ADDR;
          wdata_q <= '0;
          wait_q  <= WAIT_INIT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            pass_q <= pass_d;
            if (pass_d == iter_q) begin
              read_q  <= 1'b1;
              be_q    <= 4'hf;
              addr_q  <= {BANK_XN, idx_q};
              state_q <= S_RD_X;
            end else begin
              state_q <= S_TRIG;
            end
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        S_RD_X: begin
          // xn read is normally issued on entry; after the load phase the
          // bus is still busy with the last y write, so issue it here.
          read_q <= 1'b1;
          be_q   <= 4'hf;
          if (read_q) begin
            addr_q  <= {BANK_YN, idx_q};
            state_q <= S_RD_Y;
          end else begin
            addr_q <= {BANK_XN, idx_q};
          end
        end
        S_RD_Y: begin
          xn_q    <= bus.data_in;
          state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (!out_valid_q) begin
            yn_q        <= bus.data_in;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 14'd1;
              read_q  <= 1'b1;
              be_q    <= 4'hf;
              addr_q  <= {BANK_XN, idx_q + 14'd1};
              state_q <= S_RD_X;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_xn    = xn_q;
  assign bus.out_yn    = yn_q;
  assign bus.read      = read_q;
  assign bus.write     = write_q;
  assign bus.be        = be_q;
  assign bus.address   = addr_q;
  assign bus.data_out  = wdata_q;

endmodule

// File: tb/tb_mand_sequencer.sv
// Bench for mand_sequencer with a bank-memory slave and a stand-in
// compute unit (xn = xn*3 + x0, yn = yn ^ (y0 + 1) per trigger).
module tb_mand_sequencer;
  import mand_sequencer_pkg::*;

  localparam int P = 8;
  localparam int W = 12;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] iterations = '0;
  logic        busy;
  logic        done;

  mand_sequencer_if bus();

  mand_sequencer #(.N_POINTS(P), .N_WAIT(W)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .iterations (iterations),
    .busy       (busy),
    .done       (done),
    .bus        (bus.master)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xin(int k, int i);
    return 32'h3F80_0000 + 32'(k * 256) + 32'(i);
  endfunction
  function automatic logic [31:0] yin(int k, int i);
    return ~xin(k, i);
  endfunction
  function automatic logic [31:0] xn0(int i);
    return 32'hA000_0000 | 32'(i);
  endfunction
  function automatic logic [31:0] yn0(int i);
    return 32'h5000_0000 | 32'(i);
  endfunction
  function automatic logic [31:0] exp_xn(int k, int i, int it);
    logic [31:0] v;
    v = xn0(i);
    for (int j = 0; j < it; j++) v = v * 32'd3 + xin(k, i);
    return v;
  endfunction
  function automatic logic [31:0] exp_yn(int k, int i, int it);
    logic [31:0] v;
    v = yn0(i);
    for (int j = 0; j < it; j++) v = v ^ (yin(k, i) + 32'd1);
    return v;
  endfunction

  // Slave model: bank memories, trigger unit, bus logs
  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    int          t;
  } wr_t;

  logic [31:0] m_px [P];
  logic [31:0] m_py [P];
  logic [31:0] m_xn [P];
  logic [31:0] m_yn [P];
  wr_t         wlog [$];
  logic [15:0] rlog [$];
  logic        preload = 1'b0;
  int          cyc = 0;
  int          proto_bad = 0;

  always @(posedge clock) begin
    int ix;
    ix = int'(bus.address[13:0]);
    cyc <= cyc + 1;
    if (preload) begin
      wlog.delete();
      rlog.delete();
      for (int i = 0; i < P; i++) begin
        m_xn[i] <= xn0(i);
        m_yn[i] <= yn0(i);
      end
    end
    if ((bus.read && bus.write) ||
        (bus.be !== ((bus.read || bus.write) ? 4'hf : 4'h0)))
      proto_bad <= proto_bad + 1;
    if (bus.write) begin
      wlog.push_back('{bus.address, bus.data_out, cyc});
      if (bus.address == TRIG_ADDR) begin
        for (int i = 0; i < P; i++) begin
          m_xn[i] <= m_xn[i] * 32'd3 + m_px[i];
          m_yn[i] <= m_yn[i] ^ (m_py[i] + 32'd1);
        end
      end else if (ix < P) begin
        if (bus.address[15:14] == BANK_POSX) m_px[ix] <= bus.data_out;
        if (bus.address[15:14] == BANK_POSY) m_py[ix] <= bus.data_out;
      end
    end
    if (bus.read) begin
      rlog.push_back(bus.address);
      if (ix < P) begin
        unique case (bus.address[15:14])
          BANK_POSX: bus.data_in <= m_px[ix];
          BANK_POSY: bus.data_in <= m_py[ix];
          BANK_XN:   bus.data_in <= m_xn[ix];
          default:   bus.data_in <= m_yn[ix];
        endcase
      end else begin
        bus.data_in <= 32'hDEAD_BEEF;
      end
    end
  end

  typedef struct {
    int iter;
    bit gap;
    int stall_idx;
    int stall_len;
    bit abuse;
    int exp_writes;
  } case_t;

  task automatic run_case(int k, case_t c);
    int ii, oi, n, stall_n, last_hs, seq_bad, stall_bad;
    bit done_seen, stalling;
    ii = 0; oi = 0; n = 0; stall_n = 0; last_hs = -10;
    seq_bad = 0; stall_bad = 0; done_seen = 0;
    @(negedge clock);
    preload = 1'b1;
    @(negedge clock);
    preload = 1'b0;
    start = 1'b1;
    iterations = 16'(c.iter);
    @(negedge clock);
    start = 1'b0;
    check($sformatf("c%0d busy_after_start", k), 64'(busy), 64'd1);
    while (!done_seen && n < 2000) begin
      if (c.abuse && n == 3) begin
        start = 1'b1;
        iterations = 16'(c.iter + 5);
      end else begin
        start = 1'b0;
      end
      bus.in_valid = (ii < P) && (!c.gap || (n % 2 == 1));
      bus.in_x = xin(k, ii);
      bus.in_y = yin(k, ii);
      if (bus.in_valid && bus.in_ready) ii++;
      stalling = (oi == c.stall_idx) && bus.out_valid &&
                 (stall_n < c.stall_len);
      bus.out_ready = !stalling;
      if (stalling) begin
        stall_n++;
        if (bus.out_xn !== exp_xn(k, oi, c.iter) ||
            bus.out_yn !== exp_yn(k, oi, c.iter) || bus.read)
          stall_bad++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("c%0d out_xn[%0d]", k, oi),
              64'(bus.out_xn), 64'(exp_xn(k, oi, c.iter)));
        check($sformatf("c%0d out_yn[%0d]", k, oi),
              64'(bus.out_yn), 64'(exp_yn(k, oi, c.iter)));
        oi++;
        last_hs = n;
      end
      if (done) begin
        done_seen = 1'b1;
        check($sformatf("c%0d done_timing", k), 64'(n), 64'(last_hs + 1));
        check($sformatf("c%0d busy_at_done", k), 64'(busy), 64'd0);
        check($sformatf("c%0d outputs", k), 64'(oi), 64'(P));
        if (c.abuse) start = 1'b1;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    if (!done_seen) check($sformatf("c%0d done_timeout", k), 64'd0, 64'd1);
    repeat (3) @(negedge clock);
    check($sformatf("c%0d idle_after_done", k), 64'(busy), 64'd0);
    check($sformatf("c%0d write_count", k),
          64'(wlog.size()), 64'(c.exp_writes));
    if (wlog.size() == c.exp_writes) begin
      for (int i = 0; i < P; i++) begin
        if (wlog[2*i].a !== {BANK_POSX, 14'(i)} ||
            wlog[2*i].d !== xin(k, i)) seq_bad++;
        if (wlog[2*i+1].a !== {BANK_POSY, 14'(i)} ||
            wlog[2*i+1].d !== yin(k, i)) seq_bad++;
      end
      for (int j = 0; j < c.iter; j++) begin
        if (wlog[2*P+j].a !== TRIG_ADDR || wlog[2*P+j].d !== '0) seq_bad++;
        if (j > 0 && wlog[2*P+j].t - wlog[2*P+j-1].t != W + 1) seq_bad++;
      end
    end
    check($sformatf("c%0d write_seq", k), 64'(seq_bad), 64'd0);
    seq_bad = 0;
    if (rlog.size() != 2 * P) seq_bad++;
    else
      for (int i = 0; i < P; i++) begin
        if (rlog[2*i]   !== {BANK_XN, 14'(i)}) seq_bad++;
        if (rlog[2*i+1] !== {BANK_YN, 14'(i)}) seq_bad++;
      end
    check($sformatf("c%0d read_seq", k), 64'(seq_bad), 64'd0);
    check($sformatf("c%0d stall_len", k), 64'(stall_n),
          64'(c.stall_idx >= 0 ? c.stall_len : 0));
    check($sformatf("c%0d stall_hold", k), 64'(stall_bad), 64'd0);
    check($sformatf("c%0d protocol", k), 64'(proto_bad), 64'd0);
  endtask

  case_t tbl [5];

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    tbl[0] = '{0, 1'b0, -1, 0,  1'b0, 2*P};
    tbl[1] = '{3, 1'b0, -1, 0,  1'b0, 2*P + 3};
    tbl[2] = '{0, 1'b1, -1, 0,  1'b0, 2*P};
    tbl[3] = '{1, 1'b0, 5,  10, 1'b1, 2*P + 1};
    tbl[4] = '{2, 1'b1, 3,  4,  1'b1, 2*P + 2};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_ctrl",
          64'({busy, done, bus.in_ready, bus.out_valid, bus.read,
               bus.write, bus.be, bus.address, bus.data_out}), 64'd0);
    check("reset_data", {bus.out_xn, bus.out_yn}, 64'd0);
    rst_n = 1'b1;

    // Reset while LOAD_Y holds idx 5 (bus shows the posx[5] write)
    @(negedge clock);
    start = 1'b1;
    iterations = 16'd2;
    @(negedge clock);
    start = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    while (!(bus.write && bus.address == 16'h0005) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("reach_idx5", 64'(n < 200), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes",
          64'({bus.write, bus.in_ready, busy}), 64'd0);
    @(negedge clock);
    check("rst_mid_next",
          64'({bus.write, bus.read, bus.in_ready, busy}), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_case(k, tbl[k]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
